// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction register and jump resolution
// for the instruction-fetch half of the 2-stage pipelined 4-bit CPU.
// The instruction register drives D_BUS (opcode [7:4], immediate [3:0]).
// A jump sitting on D_BUS redirects the PC and squashes the byte fetched
// in the same cycle, which costs exactly one bubble.
module fetch_stage #(
  parameter int unsigned AW     = 4,
  parameter logic [7:0]  NOP    = 8'h00,
  parameter logic [3:0]  JMP_OP = 4'hF,
  parameter logic [3:0]  JNC_OP = 4'hE
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          cflag,
  input  logic [7:0]    rom_data,
  output logic [AW-1:0] rom_addr,
  output logic [7:0]    D_BUS,
  output logic          branch_taken,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2,
    ST_PAUSE  = 2'd3
  } state_e;

  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    ir_q, ir_d;
  logic          bt_q, bt_d;
  state_e        state_q, state_d;
  logic          take_s;

  // Jump decode on the instruction register. Only RUN can hold a real
  // instruction; FILL/SQUASH/PAUSE always carry the NOP, so they never jump.
  always_comb begin
    take_s = 1'b0;
    if (state_q == ST_RUN) begin
      if (ir_q[7:4] == JMP_OP) begin
        take_s = 1'b1;
      end else if ((ir_q[7:4] == JNC_OP) && (cflag == 1'b0)) begin
        take_s = 1'b1;
      end else begin
        take_s = 1'b0;
      end
    end else begin
      take_s = 1'b0;
    end
  end

  // Next-state selection: jump beats pause beats normal fetch. A jump is
  // honoured even with run low because it has already executed downstream.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = NOP;
    bt_d    = 1'b0;
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (take_s) begin
          pc_d    = AW'(ir_q[3:0]);
          ir_d    = NOP;
          bt_d    = 1'b1;
          state_d = ST_SQUASH;
        end else if (!run) begin
          pc_d    = pc_q;
          ir_d    = NOP;
          bt_d    = 1'b0;
          state_d = ST_PAUSE;
        end else begin
          pc_d    = pc_q + AW'(1);
          ir_d    = rom_data;
          bt_d    = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_FILL, ST_SQUASH, ST_PAUSE: begin
        if (!run) begin
          pc_d    = pc_q;
          ir_d    = NOP;
          bt_d    = 1'b0;
          state_d = ST_PAUSE;
        end else begin
          pc_d    = pc_q + AW'(1);
          ir_d    = rom_data;
          bt_d    = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        pc_d    = pc_q;
        ir_d    = NOP;
        bt_d    = 1'b0;
        state_d = ST_FILL;
      end
    endcase
  end

  // Pipeline registers; reset parks the stage in FILL with a NOP on D_BUS
  // and drops any jump that was in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      ir_q    <= NOP;
      bt_q    <= 1'b0;
      state_q <= ST_FILL;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      bt_q    <= bt_d;
      state_q <= state_d;
    end
  end

  assign rom_addr     = pc_q;
  assign D_BUS        = ir_q;
  assign branch_taken = bt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios with literal expectations, followed by
// randomized ROM contents, run/cflag and asynchronous resets, all compared
// every cycle against a behavioural model of the fetch stage.
module tb_fetch_stage;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b1;
  logic       cflag = 1'b0;
  logic [7:0] rom_data;
  logic [3:0] rom_addr;
  logic [7:0] D_BUS;
  logic       branch_taken;
  logic [1:0] state;

  logic [7:0] rom [16];
  assign rom_data = rom[rom_addr];

  int errors = 0;
  int checks = 0;

  // behavioural model: PC, D_BUS, branch pulse, state code
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  logic       m_bt;
  logic [1:0] m_st;
  bit         cmp_en = 1'b0;

  always #5 clock = ~clock;

  fetch_stage dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .cflag       (cflag),
    .rom_data    (rom_data),
    .rom_addr    (rom_addr),
    .D_BUS       (D_BUS),
    .branch_taken(branch_taken),
    .state       (state)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] a, input logic [7:0] d,
                            input logic bt, input logic [1:0] st);
    check({tag, ".rom_addr"}, {4'h0, rom_addr}, {4'h0, a});
    check({tag, ".D_BUS"}, D_BUS, d);
    check({tag, ".branch_taken"}, {7'h0, branch_taken}, {7'h0, bt});
    check({tag, ".state"}, {6'h0, state}, {6'h0, st});
  endtask

  task automatic model_reset();
    m_pc = 4'h0;
    m_ir = 8'h00;
    m_bt = 1'b0;
    m_st = 2'd0;
  endtask

  // One clock edge of the stage, from the priority rules: jump, pause, fetch.
  task automatic model_step();
    bit take;
    take = (m_ir[7:4] == 4'hF) || ((m_ir[7:4] == 4'hE) && !cflag);
    if (take) begin
      m_pc = m_ir[3:0];
      m_ir = 8'h00;
      m_bt = 1'b1;
      m_st = 2'd2;
    end else if (!run) begin
      m_ir = 8'h00;
      m_bt = 1'b0;
      m_st = 2'd3;
    end else begin
      m_ir = rom[m_pc];
      m_pc = m_pc + 4'd1;
      m_bt = 1'b0;
      m_st = 2'd1;
    end
  endtask

  // Per-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("cmp.rom_addr", {4'h0, rom_addr}, {4'h0, m_pc});
      check("cmp.D_BUS", D_BUS, m_ir);
      check("cmp.branch_taken", {7'h0, branch_taken}, {7'h0, m_bt});
      check("cmp.state", {6'h0, state}, {6'h0, m_st});
    end
  end

  task automatic cycle();
    @(posedge clock);
    if (reset) model_step();
    #1;
  endtask

  // Asynchronous reset: outputs must clear at once; release on a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    expect_out("reset", 4'h0, 8'h00, 1'b0, 2'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 16; i++) rom[i] = 8'h10 + 8'(i);
  endtask

  initial begin
    // sequential fetch with wrap
    fill_seq();
    run = 1'b1;
    cflag = 1'b0;
    do_reset();
    cmp_en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cycle();
      check("seq.D_BUS", D_BUS, 8'h10 + 8'((k - 1) % 16));
      check("seq.rom_addr", {4'h0, rom_addr}, 8'(k % 16));
    end

    // JMP 7 at address 2, 55 is squashed
    fill_seq();
    rom[2] = 8'hF7; rom[3] = 8'h55; rom[7] = 8'h33;
    do_reset();
    repeat (3) cycle();
    expect_out("jmp.a", 4'h3, 8'hF7, 1'b0, 2'd1);
    cycle();
    expect_out("jmp.b", 4'h7, 8'h00, 1'b1, 2'd2);
    cycle();
    expect_out("jmp.c", 4'h8, 8'h33, 1'b0, 2'd1);

    // JNC not taken with carry set
    fill_seq();
    rom[4] = 8'hE9;
    cflag = 1'b1;
    do_reset();
    repeat (5) cycle();
    expect_out("jnc1.a", 4'h5, 8'hE9, 1'b0, 2'd1);
    cycle();
    expect_out("jnc1.b", 4'h6, 8'h15, 1'b0, 2'd1);

    // JNC taken with carry clear
    cflag = 1'b0;
    do_reset();
    repeat (5) cycle();
    cycle();
    expect_out("jnc0.a", 4'h9, 8'h00, 1'b1, 2'd2);
    cycle();
    expect_out("jnc0.b", 4'hA, 8'h19, 1'b0, 2'd1);

    // pause for three cycles while 12 is on D_BUS
    fill_seq();
    do_reset();
    repeat (3) cycle();
    expect_out("pause.pre", 4'h3, 8'h12, 1'b0, 2'd1);
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      expect_out("pause.hold", 4'h3, 8'h00, 1'b0, 2'd3);
    end
    run = 1'b1;
    cycle();
    expect_out("pause.res1", 4'h4, 8'h13, 1'b0, 2'd1);
    cycle();
    expect_out("pause.res2", 4'h5, 8'h14, 1'b0, 2'd1);

    // jump in the same cycle as run drops
    fill_seq();
    rom[3] = 8'hFA;
    do_reset();
    repeat (4) cycle();
    expect_out("jrun0.pre", 4'h4, 8'hFA, 1'b0, 2'd1);
    run = 1'b0;
    cycle();
    expect_out("jrun0.a", 4'hA, 8'h00, 1'b1, 2'd2);
    cycle();
    expect_out("jrun0.b", 4'hA, 8'h00, 1'b0, 2'd3);
    run = 1'b1;

    // async reset mid-cycle with F5 on D_BUS: jump must be dropped
    fill_seq();
    rom[3] = 8'hF5;
    do_reset();
    repeat (4) cycle();
    expect_out("arst.pre", 4'h4, 8'hF5, 1'b0, 2'd1);
    #2;
    do_reset();
    cycle();
    expect_out("arst.a", 4'h1, 8'h10, 1'b0, 2'd1);
    cycle();
    expect_out("arst.b", 4'h2, 8'h11, 1'b0, 2'd1);

    // jump to own address loops JMP / NOP
    fill_seq();
    rom[5] = 8'hF5;
    do_reset();
    repeat (6) cycle();
    expect_out("self.a", 4'h6, 8'hF5, 1'b0, 2'd1);
    cycle();
    expect_out("self.b", 4'h5, 8'h00, 1'b1, 2'd2);
    cycle();
    expect_out("self.c", 4'h6, 8'hF5, 1'b0, 2'd1);
    cycle();
    expect_out("self.d", 4'h5, 8'h00, 1'b1, 2'd2);

    // randomized phase, checked by the per-cycle comparison
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        for (int i = 0; i < 16; i++) begin
          if ($urandom_range(0, 9) < 3)
            rom[i] = {($urandom_range(0, 1) == 1) ? 4'hF : 4'hE, 4'($urandom_range(0, 15))};
          else
            rom[i] = 8'($urandom_range(0, 255));
        end
      end
      run   = ($urandom_range(0, 9) < 8);
      cflag = 1'($urandom_range(0, 1));
      cycle();
      if ($urandom_range(0, 199) == 0) begin
        #2;
        do_reset();
      end
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
